// File: rtl/ad7265_emu_if.sv
// ----------------------------------------------------------------------------
// ad7265_emu_if -- serial-side bus between an AD7265 master and the emulator.
//
// Signals:
//   adc_sclk  master -> adc  serial clock (idles high)
//   adc_ncs   master -> adc  active-low chip select
//   adc_addr  master -> adc  3-bit mux address, valid before adc_ncs falls
//   adc_rng   master -> adc  range select
//   adc_a     adc -> master  serial data, channel A
//   adc_b     adc -> master  serial data, channel B
//   adc_oe    adc -> master  pad output enable for adc_a/adc_b
//
// Modports: master (drives sclk/ncs/addr/rng), slave (drives a/b/oe).
// ----------------------------------------------------------------------------
interface ad7265_emu_if;
  logic       adc_sclk;
  logic       adc_ncs;
  logic [2:0] adc_addr;
  logic       adc_rng;
  logic       adc_a;
  logic       adc_b;
  logic       adc_oe;

  modport master (
    output adc_sclk, adc_ncs, adc_addr, adc_rng,
    input  adc_a, adc_b, adc_oe
  );

  modport slave (
    input  adc_sclk, adc_ncs, adc_addr, adc_rng,
    output adc_a, adc_b, adc_oe
  );
endinterface

// File: rtl/ad7265_emu.sv
// ----------------------------------------------------------------------------
// ad7265_emu -- emulates the serial side of an AD7265 dual ADC so an AD7265
// master can run in loopback / hardware-in-the-loop.
//
// The host loads two 8x12 sample banks (A, B). Each chip-select frame from the
// master captures slot [adc_addr] of both banks into 14-bit shift registers
// ({2'b00, sample}) that are shifted out MSB first on adc_sclk falling edges.
//
// Parameters:
//   SYNC_STAGES  synchroniser depth for adc_sclk/adc_ncs/adc_addr/adc_rng,
//                legal values 2..4. The master must hold every sclk half
//                period and every ncs high time for >= SYNC_STAGES+2 clks.
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   wr_en        host write strobe (one cycle per write)
//   wr_sel       bank select, 0 = A, 1 = B
//   wr_addr      slot index 0..7
//   wr_data      12-bit sample
//   short_clr    clears short_frame
//   frame_cnt    count of completed frames (wraps)
//   short_frame  sticky: a frame ended before all bits were shifted
//   bus          ad7265_emu_if.slave serial bus
//
// Build option:
//   AD7265_EMU_RNG_EN  when defined, a latched adc_rng = 1 halves the captured
//                      sample ({1'b0, sample[11:1]}), emulating the 2xVREF
//                      range. Undefined: adc_rng is ignored.
// ----------------------------------------------------------------------------
module ad7265_emu #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic        wr_sel,
  input  logic [2:0]  wr_addr,
  input  logic [11:0] wr_data,
  input  logic        short_clr,
  output logic [15:0] frame_cnt,
  output logic        short_frame,
  ad7265_emu_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_TRAIL} state_t;

  // Synchroniser: one 6-bit word per stage, {rng, addr[2:0], ncs, sclk}.
  logic [5:0]  r_sync [SYNC_STAGES];
  logic [5:0]  w_raw;
  logic [5:0]  w_sync;
  logic        w_sclk_s, w_ncs_s, w_rng_s;
  logic [2:0]  w_addr_s;
  logic        r_sclk_d, r_ncs_d;
  logic        w_sclk_fall, w_ncs_fall, w_ncs_rise;

  logic [11:0] r_bank_a [8];
  logic [11:0] r_bank_b [8];
  logic [11:0] w_cap_a, w_cap_b;

  state_t      r_state, w_state_nxt;
  logic [13:0] r_sh_a, r_sh_b;
  logic [3:0]  r_bit_cnt;
  logic [15:0] r_frame_cnt;
  logic        r_short;
  logic        w_load, w_shift, w_done, w_short;
  logic        w_oe;

  assign w_raw = {bus.adc_rng, bus.adc_addr, bus.adc_ncs, bus.adc_sclk};

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_sclk_d <= 1'b0;
      r_ncs_d  <= 1'b0;
    end else begin
      r_sync[0] <= w_raw;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_sclk_d <= w_sclk_s;
      r_ncs_d  <= w_ncs_s;
    end
  end

  assign w_sync      = r_sync[SYNC_STAGES-1];
  assign w_sclk_s    = w_sync[0];
  assign w_ncs_s     = w_sync[1];
  assign w_addr_s    = w_sync[4:2];
  assign w_rng_s     = w_sync[5];
  // ncs resets low in the synchroniser, so a frame already open when reset
  // releases produces no falling edge until ncs has been seen high again.
  assign w_sclk_fall = r_sclk_d & ~w_sclk_s;
  assign w_ncs_fall  = r_ncs_d & ~w_ncs_s;
  assign w_ncs_rise  = ~r_ncs_d & w_ncs_s;

  // NOTE: the banks are small register arrays, so they take the reset like
  // any other flop; a RAM macro would need an explicit clear sequence instead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        r_bank_a[i] <= '0;
        r_bank_b[i] <= '0;
      end
    end else if (wr_en) begin
      if (wr_sel) r_bank_b[wr_addr] <= wr_data;
      else        r_bank_a[wr_addr] <= wr_data;
    end
  end

  // Capture reads the pre-edge bank contents, so a write landing on the
  // capture edge only shows up in the following frame.
`ifdef AD7265_EMU_RNG_EN
  assign w_cap_a = w_rng_s ? {1'b0, r_bank_a[w_addr_s][11:1]} : r_bank_a[w_addr_s];
  assign w_cap_b = w_rng_s ? {1'b0, r_bank_b[w_addr_s][11:1]} : r_bank_b[w_addr_s];
`else
  logic w_unused_rng;
  assign w_unused_rng = w_rng_s;
  assign w_cap_a      = r_bank_a[w_addr_s];
  assign w_cap_b      = r_bank_b[w_addr_s];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_done      = 1'b0;
    w_short     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_ncs_fall) begin
          w_state_nxt = S_SHIFT;
          w_load      = 1'b1;
        end
      end
      S_SHIFT: begin
        if (w_ncs_rise) begin
          w_state_nxt = S_IDLE;
          w_short     = 1'b1;
        end else if (w_sclk_fall) begin
          w_shift = 1'b1;
          if (r_bit_cnt == 4'd12) w_state_nxt = S_TRAIL;
        end
      end
      S_TRAIL: begin
        if (w_ncs_rise) begin
          w_state_nxt = S_IDLE;
          w_done      = 1'b1;
        end else if (w_sclk_fall) begin
          // Register is already zero below bit 13, so shifting drives 0.
          w_shift = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_a      <= '0;
      r_sh_b      <= '0;
      r_bit_cnt   <= '0;
      r_frame_cnt <= '0;
      r_short     <= 1'b0;
    end else begin
      if (w_load) begin
        r_sh_a    <= {2'b00, w_cap_a};
        r_sh_b    <= {2'b00, w_cap_b};
        r_bit_cnt <= '0;
      end else if (w_shift) begin
        r_sh_a <= {r_sh_a[12:0], 1'b0};
        r_sh_b <= {r_sh_b[12:0], 1'b0};
        if (r_state == S_SHIFT) r_bit_cnt <= r_bit_cnt + 4'd1;
      end
      if (w_done) r_frame_cnt <= r_frame_cnt + 16'd1;
      // A new short frame wins over a simultaneous clear.
      r_short <= w_short | (r_short & ~short_clr);
    end
  end

  // Outputs come straight from the state register and shift MSBs; gating with
  // oe keeps the data lines at 0 in IDLE whatever the shift registers hold.
  assign w_oe        = (r_state != S_IDLE);
  assign bus.adc_oe  = w_oe;
  assign bus.adc_a   = r_sh_a[13] & w_oe;
  assign bus.adc_b   = r_sh_b[13] & w_oe;
  assign frame_cnt   = r_frame_cnt;
  assign short_frame = r_short;

endmodule

// File: tb/tb_ad7265_emu.sv
// ----------------------------------------------------------------------------
// tb_ad7265_emu -- self-checking bench for ad7265_emu.
// Acts as the AD7265 master: drives chip-select frames, samples adc_a/adc_b
// before every sclk falling edge, and compares against hand-computed values.
// ----------------------------------------------------------------------------
module tb_ad7265_emu;

  localparam int S = 2;        // synchroniser depth under test
  localparam int H = S + 3;    // sclk half period / ncs high time in clks

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic        wr_sel;
  logic [2:0]  wr_addr;
  logic [11:0] wr_data;
  logic        short_clr;
  logic [15:0] frame_cnt;
  logic        short_frame;

  ad7265_emu_if bus();

  ad7265_emu #(.SYNC_STAGES(S)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_sel      (wr_sel),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .short_clr   (short_clr),
    .frame_cnt   (frame_cnt),
    .short_frame (short_frame),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0]  addr;
    logic        rng;
    int          falls;
    bit          chk_data;
    logic [11:0] exp_a;
    logic [11:0] exp_b;
    logic [15:0] exp_cnt;
    logic        exp_short;
  } vec_t;

  logic [11:0] a_init [8] = '{12'h123, 12'h012, 12'h9AB, 12'h678,
                              12'h456, 12'h789, 12'hF00, 12'h0F1};
  logic [11:0] b_init [8] = '{12'h800, 12'hFED, 12'h001, 12'h5A5,
                              12'hA5A, 12'h3C3, 12'hFFF, 12'h7E7};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance n rising edges, then step off the edge before driving/sampling.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic sel, input logic [2:0] a, input logic [11:0] d);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = a;
    wr_data = d;
    tick(1);
    wr_en   = 1'b0;
  endtask

  task automatic load_banks();
    for (int i = 0; i < 8; i++) begin
      wr(1'b0, 3'(i), a_init[i]);
      wr(1'b1, 3'(i), b_init[i]);
    end
  endtask

  // One chip-select frame with 'falls' sclk periods. wr_at = 0 writes on the
  // capture edge, wr_at = k > 0 writes after falling edge k, -1 = no write.
  // Data is sampled before each falling edge; 2 leading zeros, 12 data bits.
  task automatic run_frame(input logic [2:0] addr, input logic rng, input int falls,
                           input int wr_at, input logic wsel, input logic [2:0] waddr,
                           input logic [11:0] wdata,
                           output logic [11:0] rd_a, output logic [11:0] rd_b);
    logic [15:0] word_a, word_b;
    word_a = '0;
    word_b = '0;
    bus.adc_addr = addr;
    bus.adc_rng  = rng;
    tick(H);
    bus.adc_ncs = 1'b0;
    if (wr_at == 0) begin
      tick(S);
      wr(wsel, waddr, wdata);
      tick(H - S - 1);
    end else begin
      tick(H);
    end
    for (int k = 0; k < falls; k++) begin
      if (k < 16) begin
        word_a = {word_a[14:0], bus.adc_a};
        word_b = {word_b[14:0], bus.adc_b};
      end
      bus.adc_sclk = 1'b0;
      if (wr_at == k + 1) begin
        wr(wsel, waddr, wdata);
        tick(H - 1);
      end else begin
        tick(H);
      end
      bus.adc_sclk = 1'b1;
      tick(H);
    end
    bus.adc_ncs = 1'b1;
    tick(H + S + 2);
    rd_a = word_a[13:2];
    rd_b = word_b[13:2];
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [11];
    logic [11:0] ra, rb;

    rst_n        = 1'b0;
    wr_en        = 1'b0;
    wr_sel       = 1'b0;
    wr_addr      = '0;
    wr_data      = '0;
    short_clr    = 1'b0;
    bus.adc_sclk = 1'b1;
    bus.adc_ncs  = 1'b1;
    bus.adc_addr = '0;
    bus.adc_rng  = 1'b0;

    // ---------------- reset state ----------------
    tick(3);
    rst_n = 1'b1;
    tick(H + S);
    check("rst_oe",    bus.adc_oe,  0);
    check("rst_a",     bus.adc_a,   0);
    check("rst_b",     bus.adc_b,   0);
    check("rst_cnt",   frame_cnt,   0);
    check("rst_short", short_frame, 0);

    // Banks read back as zero before any write.
    run_frame(3'd5, 1'b0, 16, -1, 1'b0, 3'd0, 12'h0, ra, rb);
    check("zero_a",   ra,        12'h000);
    check("zero_b",   rb,        12'h000);
    check("zero_cnt", frame_cnt, 16'd1);

    load_banks();

    // ---------------- vector table ----------------
    vecs[0] = '{addr: 3'd1, rng: 1'b0, falls: 16, chk_data: 1'b1,
                exp_a: 12'h012, exp_b: 12'hFED, exp_cnt: 16'd2, exp_short: 1'b0};
    for (int i = 0; i < 8; i++)
      vecs[i+1] = '{addr: 3'(i), rng: 1'b0, falls: 16, chk_data: 1'b1,
                    exp_a: a_init[i], exp_b: b_init[i],
                    exp_cnt: 16'(3 + i), exp_short: 1'b0};
`ifdef AD7265_EMU_RNG_EN
    vecs[9] = '{addr: 3'd2, rng: 1'b1, falls: 16, chk_data: 1'b1,
                exp_a: 12'h4D5, exp_b: 12'h000, exp_cnt: 16'd11, exp_short: 1'b0};
`else
    vecs[9] = '{addr: 3'd2, rng: 1'b1, falls: 16, chk_data: 1'b1,
                exp_a: 12'h9AB, exp_b: 12'h001, exp_cnt: 16'd11, exp_short: 1'b0};
`endif
    vecs[10] = '{addr: 3'd3, rng: 1'b0, falls: 6, chk_data: 1'b0,
                 exp_a: 12'h000, exp_b: 12'h000, exp_cnt: 16'd11, exp_short: 1'b1};

    for (int i = 0; i < 11; i++) begin
      run_frame(vecs[i].addr, vecs[i].rng, vecs[i].falls, -1, 1'b0, 3'd0, 12'h0, ra, rb);
      if (vecs[i].chk_data) begin
        check($sformatf("vec%0d_a", i), ra, vecs[i].exp_a);
        check($sformatf("vec%0d_b", i), rb, vecs[i].exp_b);
      end
      check($sformatf("vec%0d_cnt", i),   frame_cnt,   vecs[i].exp_cnt);
      check($sformatf("vec%0d_short", i), short_frame, vecs[i].exp_short);
      check($sformatf("vec%0d_idle_oe", i), bus.adc_oe, 0);
    end

    // short_clr pulse clears the sticky flag.
    short_clr = 1'b1;
    tick(1);
    short_clr = 1'b0;
    tick(1);
    check("short_clr", short_frame, 0);

    // ---------------- write mid-frame to the slot being read ----------------
    run_frame(3'd3, 1'b0, 16, 5, 1'b0, 3'd3, 12'hABC, ra, rb);
    check("midwr_old_a", ra,        12'h678);
    check("midwr_cnt",   frame_cnt, 16'd12);
    run_frame(3'd3, 1'b0, 16, -1, 1'b0, 3'd0, 12'h0, ra, rb);
    check("midwr_new_a", ra,        12'hABC);

    // ---------------- write on the capture edge ----------------
    run_frame(3'd4, 1'b0, 16, 0, 1'b1, 3'd4, 12'h111, ra, rb);
    check("capwr_old_b", rb, 12'hA5A);
    check("capwr_a",     ra, 12'h456);
    run_frame(3'd4, 1'b0, 16, -1, 1'b0, 3'd0, 12'h0, ra, rb);
    check("capwr_new_b", rb,        12'h111);
    check("capwr_cnt",   frame_cnt, 16'd15);

    // ---------------- output latency, then short frame vs clear ----------------
    bus.adc_addr = 3'd1;
    bus.adc_rng  = 1'b0;
    tick(H);
    bus.adc_ncs = 1'b0;
    tick(H);
    check("lat_oe", bus.adc_oe, 1);
    bus.adc_sclk = 1'b0; tick(H);
    bus.adc_sclk = 1'b1; tick(H);
    bus.adc_sclk = 1'b0;               // fall 2: channel B shows bit 11 = 1
    tick(S);
    check("lat_before", bus.adc_b, 0);
    tick(1);
    check("lat_after",  bus.adc_b, 1);
    tick(H - S - 1);
    bus.adc_sclk = 1'b1;
    tick(H);
    bus.adc_ncs = 1'b1;                // rise in SHIFT: short event S+1 edges later
    tick(S);
    short_clr = 1'b1;
    tick(1);
    short_clr = 1'b0;
    check("clr_collide_short", short_frame, 1);
    check("clr_collide_cnt",   frame_cnt,   16'd15);
    check("clr_collide_oe",    bus.adc_oe,  0);
    tick(2);
    short_clr = 1'b1;
    tick(1);
    short_clr = 1'b0;
    check("clr_after_collide", short_frame, 0);
    tick(H);

    // ---------------- reset during bit 7 ----------------
    bus.adc_addr = 3'd6;
    tick(H);
    bus.adc_ncs = 1'b0;
    tick(H);
    for (int k = 0; k < 7; k++) begin
      bus.adc_sclk = 1'b0; tick(H);
      bus.adc_sclk = 1'b1; tick(H);
    end
    check("midrst_pre_oe", bus.adc_oe, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_oe",    bus.adc_oe,  0);
    check("midrst_a",     bus.adc_a,   0);
    check("midrst_b",     bus.adc_b,   0);
    check("midrst_cnt",   frame_cnt,   0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    // ncs still low from the interrupted frame: must be ignored.
    for (int k = 0; k < 4; k++) begin
      bus.adc_sclk = 1'b0; tick(H);
      bus.adc_sclk = 1'b1; tick(H);
    end
    check("midrst_ignored_oe", bus.adc_oe, 0);
    bus.adc_ncs = 1'b1;
    tick(H + S + 2);
    check("midrst_ignored_cnt", frame_cnt, 0);

    run_frame(3'd6, 1'b0, 16, -1, 1'b0, 3'd0, 12'h0, ra, rb);
    check("postrst_zero_a", ra, 12'h000);
    check("postrst_zero_b", rb, 12'h000);
    load_banks();
    run_frame(3'd6, 1'b0, 16, -1, 1'b0, 3'd0, 12'h0, ra, rb);
    check("postrst_a",     ra,          12'hF00);
    check("postrst_b",     rb,          12'hFFF);
    check("postrst_cnt",   frame_cnt,   16'd2);
    check("postrst_short", short_frame, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ad7265_emu.md
AD7265_EMU -- requirements
Module: ad7265_emu

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchroniser depth on adc_sclk, adc_ncs, adc_addr and adc_rng; legal values 2..4.
REQ-002 clk  in  1  system clock; all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 wr_en  in  1  host write strobe, one cycle per write.
REQ-005 wr_sel  in  1  sample bank select: 0 = channel A, 1 = channel B.
REQ-006 wr_addr  in  3  sample slot index 0..7.
REQ-007 wr_data  in  12  sample value to store.
REQ-008 adc_sclk  in  1  serial clock from the ADC master; asynchronous to clk.
REQ-009 adc_ncs  in  1  active-low chip select from the master.
REQ-010 adc_addr  in  3  mux address from the master.
REQ-011 adc_rng  in  1  range select from the master.
REQ-012 adc_a  out  1  serial data, channel A.
REQ-013 adc_b  out  1  serial data, channel B.
REQ-014 adc_oe  out  1  output enable for the adc_a/adc_b pad tri-states.
REQ-015 frame_cnt  out  16  count of completed frames.
REQ-016 short_frame  out  1  sticky flag: frame ended early.
REQ-017 short_clr  in  1  clears short_frame.

Function
REQ-018 Block emulates the serial side of an AD7265 so the ad7265 master can run in loopback and hardware-in-the-loop.
REQ-019 Two 8x12 sample banks (A, B); wr_en writes wr_data to bank[wr_sel][wr_addr] on the next rising clk; bank contents zero after reset.
REQ-020 adc_sclk and adc_ncs pass through SYNC_STAGES flops; edges are detected on the synchronised copies.
REQ-021 Master timing limit: each adc_sclk half-period and each adc_ncs high time lasts at least SYNC_STAGES+2 clk periods.
REQ-022 FSM states IDLE, SHIFT, TRAIL; reset state IDLE.
REQ-023 IDLE to SHIFT on synchronised adc_ncs falling edge:
- synchronised adc_addr and adc_rng are latched;
- bank A and bank B slot [addr] are captured into two 14-bit shift registers {2'b00, sample};
- adc_oe rises; adc_a and adc_b drive bit 13 (0);
- bit counter loads 0.
REQ-024 In SHIFT, each synchronised adc_sclk falling edge shifts both registers left by one, zero-fills, and increments the bit counter.
REQ-025 Output latency: adc_a/adc_b change exactly SYNC_STAGES+1 clk cycles after the raw adc_sclk falling edge.
REQ-026 SHIFT to TRAIL when the bit counter reaches 13; in TRAIL, outputs hold 0 for any further sclk edges.
REQ-027 From SHIFT or TRAIL, a synchronised adc_ncs rising edge returns to IDLE and clears adc_oe the same cycle.
REQ-028 adc_ncs rise in TRAIL: frame_cnt increments, wrapping 0xFFFF to 0.
REQ-029 adc_ncs rise in SHIFT: short_frame sets and frame_cnt is unchanged.
REQ-030 short_clr and a new short-frame event in the same cycle: short_frame stays 1.
REQ-031 Writes during a frame do not alter the captured sample; they apply from the next frame.
REQ-032 Write to the captured slot in the same cycle as the capture: capture takes the old value.
REQ-033 In IDLE, adc_a and adc_b drive 0 and adc_oe drives 0.

Reset
REQ-034 rst_n low, including mid-frame, forces within the same cycle:
- FSM to IDLE;
- adc_oe, adc_a, adc_b, short_frame to 0;
- frame_cnt to 0;
- banks, shift registers and synchronisers to 0.
REQ-035 After rst_n deasserts, a frame already in progress (adc_ncs low) is ignored until adc_ncs goes high and then low again.

Configuration
REQ-036 AD7265_EMU_RNG_EN defined, latched rng = 1: the captured sample is {1'b0, sample[11:1]}, emulating the 2xVREF range.
REQ-037 AD7265_EMU_RNG_EN defined, latched rng = 0: the sample is captured unchanged.
REQ-038 AD7265_EMU_RNG_EN undefined: adc_rng is ignored and samples are captured unchanged; port list is identical in both builds.

Verification
REQ-039 Bank A slot 1 = 0x012, bank B slot 1 = 0xFED; frame with addr = 1 and 16 sclk -> master reads A = 0x012, B = 0xFED; frame_cnt = 1.
REQ-040 Addresses 0..7 cycled back to back through the ad7265 master -> each rdy returns the programmed pair; frame_cnt = 8; short_frame = 0.
REQ-041 ncs rises after 6 sclk falling edges -> short_frame = 1, frame_cnt unchanged; short_clr pulse -> short_frame = 0.
REQ-042 Bank A slot 3 overwritten with 0xABC mid-frame while reading slot 3 (old 0x678) -> this frame yields 0x678, next frame yields 0xABC.
REQ-043 rst_n pulsed low during bit 7 -> adc_oe = 0 immediately; next full frame reads correct data.
REQ-044 With AD7265_EMU_RNG_EN, rng = 1, sample 0x9AB -> 0x4D5 read; without the macro -> 0x9AB.
